// File: rtl/decoder.sv
// Optical-link receiver: synchronises the light sensor, detects a HIGH start bit,
// recovers one MSB-first packet by mid-bit sampling and offers it on valid/ready.
module decoder #(
  parameter int unsigned PACKET_SIZE = 8,
  parameter int unsigned BIT_PERIOD  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sensor,
  input  logic                   enable,
  output logic [PACKET_SIZE-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   busy,
  output logic                   frame_error,
  output logic                   overrun
);

  localparam int unsigned CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned IDX_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACKET_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [PACKET_SIZE-1:0] shift;
  logic                   s;
  logic                   sample;
  logic                   stop_sample;
  logic                   good_frame;

  assign s = sync_q[SYNC_STAGES-1];

  // Start bit is sampled half a bit in; every later sample is one full bit later.
  always_comb begin
    sample = 1'b0;
    case (state)
      START:       sample = (cnt == CNT_HALF);
      DATA, STOP:  sample = (cnt == CNT_LAST);
      default:     sample = 1'b0;
    endcase
    stop_sample = enable && (state == STOP) && sample;
    good_frame  = stop_sample && !s;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      sync_q <= '0;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
    end else begin
      state  <= state_next;
      sync_q <= SYNC_STAGES'({sync_q, sensor});
      cnt    <= (state == IDLE || sample) ? '0 : cnt + 1'b1;
      if (state == DATA && sample) begin
        shift <= PACKET_SIZE'({shift, s});
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else if (state == IDLE) begin
        idx <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (s) state_next = START;
      START: if (sample) state_next = s ? DATA : IDLE;
      DATA:  if (sample && idx == IDX_LAST) state_next = STOP;
      STOP:  if (sample) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= stop_sample && s;
      overrun     <= good_frame && valid && !ready;
      if (good_frame && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: frames are driven bit-by-bit, expected packets are queued
// at send time and popped by a monitor on every valid&&ready handshake.
module tb_decoder;

  localparam int unsigned PS = 8;
  localparam int unsigned BP = 4;
  localparam int unsigned SS = 2;

  logic          clock = 1'b0;
  logic          reset, sensor, enable, ready;
  logic [PS-1:0] data;
  logic          valid, busy, frame_error, overrun;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  int unsigned fe_base, ov_base;
  logic [PS-1:0] exp_q[$];

  decoder #(.PACKET_SIZE(PS), .BIT_PERIOD(BP), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .sensor(sensor), .enable(enable),
    .data(data), .valid(valid), .ready(ready), .busy(busy),
    .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change just after the active edge; outputs are read on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    sensor = b;
    repeat (BP) tick();
  endtask

  task automatic send(input logic [PS-1:0] pkt, input logic stop);
    drive_bit(1'b1);
    for (int i = PS - 1; i >= 0; i--) drive_bit(pkt[i]);
    drive_bit(stop);
    sensor = 1'b0;
  endtask

  always @(negedge clock) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (reset && valid && ready) begin
      check("pending_pkt", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("hs_data", {24'b0, data}, {24'b0, exp_q.pop_front()});
    end
  end

  initial begin
    reset = 1'b0; sensor = 1'b0; enable = 1'b1; ready = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    check("rst_data", {24'b0, data}, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_fe", {31'b0, frame_error}, 32'd0);
    check("rst_ov", {31'b0, overrun}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();

    // Good frame with consumer ready: one-cycle valid at the nominal latency.
    fe_base = fe_cnt; ov_base = ov_cnt;
    exp_q.push_back(8'hB6);
    send(8'b1011_0110, 1'b0);
    @(negedge clock);
    check("t1_pre_valid", {31'b0, valid}, 32'd0);
    check("t1_busy_mid", {31'b0, busy}, 32'd1);
    tick();
    @(negedge clock);
    check("t1_valid", {31'b0, valid}, 32'd1);
    check("t1_busy_done", {31'b0, busy}, 32'd0);
    @(negedge clock);
    check("t1_valid_drop", {31'b0, valid}, 32'd0);
    repeat (4) tick();
    check("t1_fe", fe_cnt - fe_base, 32'd0);
    check("t1_ov", ov_cnt - ov_base, 32'd0);
    check("t1_q_empty", exp_q.size(), 32'd0);

    // One-clock glitch must abort at the start-bit sample.
    fe_base = fe_cnt;
    sensor = 1'b1;
    tick();
    sensor = 1'b0;
    repeat (12) tick();
    @(negedge clock);
    check("t2_valid", {31'b0, valid}, 32'd0);
    check("t2_busy", {31'b0, busy}, 32'd0);
    check("t2_fe", fe_cnt - fe_base, 32'd0);

    // Stop bit HIGH: single frame_error pulse, packet discarded.
    fe_base = fe_cnt;
    send(8'h5A, 1'b1);
    repeat (12) tick();
    @(negedge clock);
    check("t3_fe", fe_cnt - fe_base, 32'd1);
    check("t3_valid", {31'b0, valid}, 32'd0);
    check("t3_data", {24'b0, data}, 32'hB6);

    // Consumer stalled: second packet dropped with overrun, first one kept.
    ready = 1'b0;
    ov_base = ov_cnt;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    repeat (3) tick();
    @(negedge clock);
    check("t4_valid", {31'b0, valid}, 32'd1);
    check("t4_data", {24'b0, data}, 32'h11);
    check("t4_ov", ov_cnt - ov_base, 32'd1);
    tick();
    ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t4_valid_drop", {31'b0, valid}, 32'd0);
    check("t4_data_hold", {24'b0, data}, 32'h11);

    // Reset mid-frame clears everything; next frame is received normally.
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    reset = 1'b0;
    sensor = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("t5_data", {24'b0, data}, 32'h0);
    check("t5_valid", {31'b0, valid}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_fe", {31'b0, frame_error}, 32'd0);
    check("t5_ov", {31'b0, overrun}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0);
    tick();
    @(negedge clock);
    check("t5_valid_new", {31'b0, valid}, 32'd1);
    check("t5_data_new", {24'b0, data}, 32'h3C);
    repeat (4) tick();

    // Abort via enable during data bit 4 of 8'hA5, then receive 8'hC3.
    fe_base = fe_cnt; ov_base = ov_cnt;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    sensor = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("t6_busy_before", {31'b0, busy}, 32'd1);
    enable = 1'b0;
    tick();
    @(negedge clock);
    check("t6_busy_after", {31'b0, busy}, 32'd0);
    tick();
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (4) tick();
    check("t6_no_valid", {31'b0, valid}, 32'd0);
    enable = 1'b1;
    repeat (4) tick();
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b0);
    tick();
    @(negedge clock);
    check("t6_valid", {31'b0, valid}, 32'd1);
    check("t6_data", {24'b0, data}, 32'hC3);
    repeat (5) tick();
    check("t6_flags", (fe_cnt - fe_base) + (ov_cnt - ov_base), 32'd0);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
